// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage RV32I-format pipeline control blocks.
//   - Opcode constants for the instruction classes the hazard logic cares about
//   - NOP_INSTR: canonical bubble (addi x0,x0,0)
//   - Instruction field positions and widths
//   - sbEntry_t: one in-flight scoreboard slot {valid, rd}
//   - hazState_t: stall controller FSM states
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 7;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int REG_W   = 5;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sbEntry_t;

   typedef enum logic {
      RUN     = 1'b0,
      STALLED = 1'b1
   } hazState_t;

endpackage

// File: rtl/rv32i_reg_usage_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_reg_usage_decoder
// Purely combinational: reports which architectural registers an instruction
// reads and whether it writes a destination register.
// Ports:
//   instruction_i  in  32  instruction to classify
//   uses_rs1_o     out  1  instruction reads rs1
//   uses_rs2_o     out  1  instruction reads rs2
//   writes_rd_o    out  1  instruction writes rd (before the x0 filter)
//   rs1_o/rs2_o/rd_o out 5 raw register fields
// ---------------------------------------------------------------------------
module rv32i_reg_usage_decoder
   import pipeline_pkg::*;
(
   input  logic [31:0]      instruction_i,
   output logic             uses_rs1_o,
   output logic             uses_rs2_o,
   output logic             writes_rd_o,
   output logic [REG_W-1:0] rs1_o,
   output logic [REG_W-1:0] rs2_o,
   output logic [REG_W-1:0] rd_o
);

   logic [OPC_W-1:0] opcode;

   // funct3/funct7 do not affect register usage; folded here only so the
   // whole instruction word is consumed.
   logic unusedFunctBits;
   assign unusedFunctBits = ^{instruction_i[31:25], instruction_i[14:12]};

   assign opcode = instruction_i[OPC_LSB +: OPC_W];
   assign rs1_o  = instruction_i[RS1_LSB +: REG_W];
   assign rs2_o  = instruction_i[RS2_LSB +: REG_W];
   assign rd_o   = instruction_i[RD_LSB  +: REG_W];

   // Classify the opcode; anything unrecognised neither reads nor writes.
   always_comb begin
      uses_rs1_o  = 1'b0;
      uses_rs2_o  = 1'b0;
      writes_rd_o = 1'b0;
      unique case (opcode)
         OPC_RTYPE: begin
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OPC_IALU, OPC_LOAD: begin
            uses_rs1_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OPC_STORE, OPC_BRANCH: begin
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// RAW hazard detector and stall controller between IF/ID and decode.
// Keeps a shift-register scoreboard of the destination registers held by the
// instructions in EX, MEM and WB; holds the front end and injects a NOP into
// ID/EX while the decode instruction reads one of them.
// Ports:
//   clock               in   1      pipeline clock
//   reset_n             in   1      synchronous active-low reset
//   id_instruction      in   32     instruction in IF/ID
//   flush               in   1      taken branch in EX, kill ID instruction
//   stall               out  1      hold PC and IF/ID (combinational)
//   id_instruction_out  out  32     instruction to decode, NOP when killed
//   stall_start         out  1      registered pulse, first cycle of a stall
//   stall_count         out  CNT_W  saturating stalled-cycle count
// ---------------------------------------------------------------------------
module hazard_stall_unit
   import pipeline_pkg::*;
#(
   parameter int HAZ_DEPTH = 3,
   parameter int CNT_W     = 16
)
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [31:0]      id_instruction,
   input  logic             flush,
   output logic             stall,
   output logic [31:0]      id_instruction_out,
   output logic             stall_start,
   output logic [CNT_W-1:0] stall_count
);

   logic             usesRs1;
   logic             usesRs2;
   logic             writesRd;
   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic [REG_W-1:0] rd;

   sbEntry_t         sb_q [HAZ_DEPTH];
   sbEntry_t         sb_d [HAZ_DEPTH];
   hazState_t        state_q;
   logic             stallStart_q;
   logic [CNT_W-1:0] stallCount_q;
   logic [CNT_W-1:0] stallCount_d;
   logic             hazard;
   logic             killId;

   rv32i_reg_usage_decoder uDecoder (
      .instruction_i (id_instruction),
      .uses_rs1_o    (usesRs1),
      .uses_rs2_o    (usesRs2),
      .writes_rd_o   (writesRd),
      .rs1_o         (rs1),
      .rs2_o         (rs2),
      .rd_o          (rd)
   );

   // A hazard is any live slot whose rd matches a non-x0 source register.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_q[i].valid) begin
            if (usesRs1 && (rs1 != '0) && (sb_q[i].rd == rs1)) hazard = 1'b1;
            if (usesRs2 && (rs2 != '0) && (sb_q[i].rd == rs2)) hazard = 1'b1;
         end
      end
   end

   // Flush outranks stall; reset forces a clean NOP with no stall request.
   assign stall              = hazard && !flush && reset_n;
   assign killId             = stall || flush || !reset_n;
   assign id_instruction_out = killId ? NOP_INSTR : id_instruction;

   // Slot 0 receives the ID instruction's writer info, or a bubble when the
   // ID instruction is not actually issued; older slots age toward WB.
   always_comb begin
      sb_d[0].valid = writesRd && (rd != '0) && !stall && !flush;
      sb_d[0].rd    = rd;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   // Counter holds at all-ones instead of wrapping.
   assign stallCount_d = (stall && (stallCount_q != '1)) ? stallCount_q + CNT_W'(1)
                                                         : stallCount_q;

   always_ff @(posedge clock) begin
      if (!reset_n) stallCount_q <= '0;
      else          stallCount_q <= stallCount_d;
   end

   // Episode tracker: pulse only on the RUN->STALLED transition.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= RUN;
         stallStart_q <= 1'b0;
      end else begin
         stallStart_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (stall) begin
                  state_q      <= STALLED;
                  stallStart_q <= 1'b1;
               end
            end
            STALLED: begin
               if (!stall) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign stall_start = stallStart_q;
   assign stall_count = stallCount_q;

endmodule
